// File: rtl/sys_pkg.sv
// Shared definitions for the reg_file command front-end:
// frame opcodes, controller state encoding and address range helper.
package sys_pkg;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_PULSE,
    RD_ADDR,
    RD_PULSE,
    RD_WAIT,
    TX_SEND
  } ctrl_state_t;

  // True when no bit at or above position aw is set in the address byte.
  function automatic logic addr_fits(
    input logic [7:0]  b,
    input int unsigned aw
  );
    logic [7:0] m;
    m = 8'hFF << aw;
    return (b & m) == 8'h00;
  endfunction

endpackage

// File: rtl/reg_file_cmd_ctrl_frame_timer.sv
// Inter-byte watchdog: loadable down-counter that flags expiry when it
// sits at zero while enabled and no reload arrives.
module frame_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Reload wins over clear so a byte arriving in IDLE arms the timer.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i & ~load_i & (cnt_q == '0);

endmodule

// File: rtl/reg_file_cmd_ctrl.sv
// Byte-stream command decoder in front of reg_file: write/read frames in,
// register strobes out, read data returned LSB byte first over valid/ready.
module reg_file_cmd_ctrl
  import sys_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LINES   = 8,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned NB     = WIDTH / 8,
  localparam int unsigned AW     = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_en,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             cmd_err
);

  localparam int unsigned KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NB - 1);
  localparam logic [KW-1:0] KONE  = KW'(1);

  ctrl_state_t           state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [NB-1:0][7:0]    wr_data_q, wr_data_d;
  logic [NB-1:0][7:0]    cap_q, cap_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  err_q, err_d;

  logic tmr_load;
  logic tmr_en;
  logic tmr_expire;

  assign tmr_en = (state_q == WR_ADDR) ||
                  (state_q == WR_DATA) ||
                  (state_q == RD_ADDR);

  assign tmr_load = rx_valid && (tmr_en || (state_q == IDLE));

  frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .clr_i    (~tmr_en),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    cap_d     = cap_q;
    k_d       = k_q;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        k_d = '0;
        if (rx_valid) begin
          if (rx_data == CMD_WR) begin
            state_d = WR_ADDR;
          end else if (rx_data == CMD_RD) begin
            state_d = RD_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      WR_ADDR, RD_ADDR: begin
        if (rx_valid) begin
          if (addr_fits(rx_data, AW)) begin
            addr_d  = rx_data[AW-1:0];
            k_d     = '0;
            state_d = (state_q == WR_ADDR) ? WR_DATA : RD_PULSE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tmr_expire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      WR_DATA: begin
        if (rx_valid) begin
          wr_data_d[k_q] = rx_data;
          if (k_q == KLAST) begin
            k_d     = '0;
            state_d = WR_PULSE;
          end else begin
            k_d = k_q + KONE;
          end
        end else if (tmr_expire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      WR_PULSE: begin
        err_d   = rx_valid;
        state_d = IDLE;
      end

      RD_PULSE: begin
        err_d   = rx_valid;
        state_d = RD_WAIT;
      end

      // rd_data is registered in reg_file, so it lands one cycle after rd_en.
      RD_WAIT: begin
        err_d   = rx_valid;
        cap_d   = rd_data;
        k_d     = '0;
        state_d = TX_SEND;
      end

      TX_SEND: begin
        err_d = rx_valid;
        if (tx_ready) begin
          if (k_q == KLAST) begin
            k_d     = '0;
            state_d = IDLE;
          end else begin
            k_d = k_q + KONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      cap_q     <= '0;
      k_q       <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      cap_q     <= cap_d;
      k_q       <= k_d;
      err_q     <= err_d;
    end
  end

  assign addr     = addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = (state_q == WR_PULSE);
  assign rd_en    = (state_q == RD_PULSE);
  assign busy     = (state_q != IDLE);
  assign cmd_err  = err_q;
  assign tx_valid = (state_q == TX_SEND);
  assign tx_data  = tx_valid ? cap_q[k_q] : 8'h00;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Directed bench for reg_file_cmd_ctrl with a small registered reg_file
// model attached; each scenario task checks its own expected values.
module tb_reg_file_cmd_ctrl;

  localparam int WIDTH   = 16;
  localparam int LINES   = 8;
  localparam int TIMEOUT = 1024;
  localparam int AW      = 3;

  logic             clk;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             cmd_err;

  int checks;
  int failures;

  int wr_cnt;
  int rd_cnt;
  int both_cnt;
  int err_cnt;

  logic [WIDTH-1:0] mem [LINES];

  reg_file_cmd_ctrl #(
    .WIDTH   (WIDTH),
    .LINES   (LINES),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .addr     (addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
    if (rd_en) rd_data <= mem[addr];
  end

  always @(negedge clk) begin
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (wr_en && rd_en) both_cnt <= both_cnt + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
  end

  initial begin
    wr_cnt = 0;
    rd_cnt = 0;
    both_cnt = 0;
    err_cnt = 0;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic write_frame(input logic [7:0] a, input logic [15:0] d);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    @(negedge clk);
  endtask

  task automatic read_frame(
    input  logic [7:0]  a,
    output logic [15:0] d,
    output logic        ok
  );
    int n;
    n = 0;
    d = '0;
    tx_ready = 1'b1;
    send_byte(8'hBB);
    send_byte(a);
    for (int i = 0; i < 12 && n < 2; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        if (n == 0) d[7:0] = tx_data;
        else d[15:8] = tx_data;
        n++;
      end
    end
    ok = (n == 2);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_valid, wr_en, rd_en, busy, cmd_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got %b exp 00000",
               {tx_valid, wr_en, rd_en, busy, cmd_err});
    end
    checks++;
    if ({tx_data, addr, wr_data} !== 27'h0) begin
      failures++;
      $display("FAIL reset_data got %h/%h/%h exp 0/0/0",
               tx_data, addr, wr_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    logic [15:0] d;
    logic ok;
    send_byte(8'hAA);
    repeat (2) @(negedge clk);
    send_byte(8'h03);
    repeat (3) @(negedge clk);
    send_byte(8'h34);
    @(negedge clk);
    send_byte(8'h12);
    checks++;
    if ({wr_en, rd_en, addr, wr_data} !== {2'b10, 3'd3, 16'h1234}) begin
      failures++;
      $display("FAIL write_strobe got en=%b%b a=%0d d=%h exp 10 3 1234",
               wr_en, rd_en, addr, wr_data);
    end
    @(negedge clk);
    checks++;
    if ({wr_en, busy} !== 2'b00) begin
      failures++;
      $display("FAIL write_done got wr_en/busy=%b%b exp 00", wr_en, busy);
    end
    write_frame(8'h05, 16'hBEEF);
    write_frame(8'h02, 16'h5A5A);
    tx_ready = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h03);
    checks++;
    if ({rd_en, wr_en, tx_valid} !== 3'b100) begin
      failures++;
      $display("FAIL read_strobe got rd/wr/txv=%b exp 100",
               {rd_en, wr_en, tx_valid});
    end
    @(negedge clk);
    checks++;
    if ({rd_en, tx_valid, busy} !== 3'b001) begin
      failures++;
      $display("FAIL read_wait got rd/txv/busy=%b exp 001",
               {rd_en, tx_valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h34}) begin
      failures++;
      $display("FAIL read_byte0 got v=%b d=%h exp 1 34", tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h12}) begin
      failures++;
      $display("FAIL read_byte1 got v=%b d=%h exp 1 12", tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL read_end got txv/busy=%b exp 00", {tx_valid, busy});
    end
    read_frame(8'h05, d, ok);
    checks++;
    if (!ok || d !== 16'hBEEF) begin
      failures++;
      $display("FAIL readback_5 got ok=%b d=%h exp 1 beef", ok, d);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    tx_ready = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h05);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'hEF) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got %0d bad cycles, last v=%b d=%h exp 0 1 ef",
               bad, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'hBE}) begin
      failures++;
      $display("FAIL bp_byte1 got v=%b d=%h exp 1 be", tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL bp_end got txv/busy=%b exp 00", {tx_valid, busy});
    end
  endtask

  task automatic test_bad_cmd;
    int w0, r0, e0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    e0 = err_cnt;
    send_byte(8'h55);
    checks++;
    if ({cmd_err, busy} !== 2'b10) begin
      failures++;
      $display("FAIL badcmd_err got err/busy=%b exp 10", {cmd_err, busy});
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wr_cnt != w0 || rd_cnt != r0 || err_cnt != e0 + 1) begin
      failures++;
      $display("FAIL badcmd_counts got wr=%0d rd=%0d err=%0d exp 0 0 1",
               wr_cnt - w0, rd_cnt - r0, err_cnt - e0);
    end
  endtask

  task automatic test_bad_addr;
    int w0;
    w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h09);
    checks++;
    if ({cmd_err, busy} !== 2'b10) begin
      failures++;
      $display("FAIL badaddr_err got err/busy=%b exp 10", {cmd_err, busy});
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (wr_cnt != w0) begin
      failures++;
      $display("FAIL badaddr_wr got %0d wr_en exp 0", wr_cnt - w0);
    end
  endtask

  task automatic test_timeout;
    int w0, bad;
    logic [15:0] d;
    logic ok;
    w0 = wr_cnt;
    bad = 0;
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h77);
    for (int i = 0; i < TIMEOUT; i++) begin
      if (i > 0) @(negedge clk);
      if (cmd_err !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL timeout_early got %0d early cycles exp 0", bad);
    end
    @(negedge clk);
    checks++;
    if ({cmd_err, busy, wr_en} !== 3'b100) begin
      failures++;
      $display("FAIL timeout_err got err/busy/wr=%b exp 100",
               {cmd_err, busy, wr_en});
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (wr_cnt != w0) begin
      failures++;
      $display("FAIL timeout_wr got %0d wr_en exp 0", wr_cnt - w0);
    end
    read_frame(8'h02, d, ok);
    checks++;
    if (!ok || d !== 16'h5A5A) begin
      failures++;
      $display("FAIL timeout_old got ok=%b d=%h exp 1 5a5a", ok, d);
    end
  endtask

  task automatic test_overrun;
    tx_ready = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h03);
    repeat (2) @(negedge clk);
    send_byte(8'h66);
    checks++;
    if ({cmd_err, tx_valid, tx_data} !== {2'b11, 8'h34}) begin
      failures++;
      $display("FAIL overrun_err got err=%b v=%b d=%h exp 1 1 34",
               cmd_err, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_err, tx_valid, tx_data} !== {2'b01, 8'h12}) begin
      failures++;
      $display("FAIL overrun_byte1 got err=%b v=%b d=%h exp 0 1 12",
               cmd_err, tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL overrun_end got txv/busy=%b exp 00", {tx_valid, busy});
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h99);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, wr_en, rd_en, tx_valid, cmd_err, addr, wr_data} !== 24'h0) begin
      failures++;
      $display("FAIL rstmid_out got busy=%b a=%0d d=%h exp 0 0 0000",
               busy, addr, wr_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (wr_cnt != w0) begin
      failures++;
      $display("FAIL rstmid_wr got %0d wr_en exp 0", wr_cnt - w0);
    end
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'hCD);
    send_byte(8'hAB);
    checks++;
    if ({wr_en, addr, wr_data} !== {1'b1, 3'd1, 16'hABCD}) begin
      failures++;
      $display("FAIL rstmid_frame got wr=%b a=%0d d=%h exp 1 1 abcd",
               wr_en, addr, wr_data);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write();
    test_backpressure();
    test_bad_cmd();
    test_bad_addr();
    test_timeout();
    test_overrun();
    test_reset_mid();
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL strobe_overlap got %0d cycles exp 0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_cmd_ctrl.md
Name: reg_file_cmd_ctrl

Overview:
- Command front-end that sits directly upstream of reg_file.
- Consumes a byte stream from the UART receiver and decodes write and read frames.
- Drives reg_file wr_en/rd_en/addr/wr_data, captures rd_data, and returns it byte-wise to the UART transmitter over a valid/ready handshake.

Parameters:
- WIDTH, 16, reg_file word width in bits; must be a multiple of 8. NB = WIDTH/8 bytes per word.
- LINES, 8, reg_file depth; AW = $clog2(LINES).
- TIMEOUT, 1024, maximum clk cycles allowed between consecutive bytes of one frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  tx_data valid; held until tx_ready.
- tx_ready  in  1  transmitter accepts tx_data in any cycle where tx_valid&tx_ready.
- addr  out  AW  reg_file address.
- wr_data  out  WIDTH  reg_file write data.
- wr_en  out  1  one-cycle write strobe.
- rd_en  out  1  one-cycle read strobe.
- rd_data  in  WIDTH  reg_file read data, registered, valid the cycle after rd_en.
- busy  out  1  high in every state except IDLE.
- cmd_err  out  1  one-cycle error pulse.

Behaviour:
- Reset: state=IDLE; tx_data=0, tx_valid=0, addr=0, wr_data=0, wr_en=0, rd_en=0, busy=0, cmd_err=0. Byte counter, timeout counter and capture register cleared.
- Frames:
  - Write: 0xAA, ADDR, D0..D(NB-1); data is LSB byte first.
  - Read: 0xBB, ADDR.
- Address byte: bits [AW-1:0] are used. Any nonzero bit above AW -> cmd_err pulse, frame dropped, return to IDLE.
- States: IDLE, WR_ADDR, WR_DATA, WR_PULSE, RD_ADDR, RD_PULSE, RD_WAIT, TX_SEND.
- IDLE: on rx_valid, 0xAA -> WR_ADDR and 0xBB -> RD_ADDR. Any other byte -> cmd_err pulse next cycle, stay IDLE.
- WR_ADDR: on rx_valid, latch addr -> WR_DATA with byte counter=0.
- WR_DATA: each rx_valid places the byte into wr_data[8k+7:8k] and increments k. When byte NB-1 is accepted in cycle N -> WR_PULSE. wr_en=1 in cycle N+1 with addr/wr_data stable, then IDLE.
- RD_ADDR: addr byte accepted in cycle N. rd_en=1 in N+1 (RD_PULSE). RD_WAIT in N+2 captures rd_data. TX_SEND from N+3.
- TX_SEND:
  - tx_valid=1, tx_data = captured byte k, LSB first.
  - On tx_valid&tx_ready, advance k; byte k+1 is presented in the next cycle.
  - After byte NB-1 handshakes, tx_valid=0 and the block returns to IDLE.
  - tx_data stays stable while tx_valid&!tx_ready.
- wr_en and rd_en are never high simultaneously; each is high for exactly one cycle per frame.
- Timeout: in WR_ADDR/WR_DATA/RD_ADDR the counter resets on each rx_valid and increments otherwise. Reaching TIMEOUT -> cmd_err pulse, IDLE, partial write discarded (no wr_en). Counter inactive in IDLE/RD_PULSE/RD_WAIT/TX_SEND.
- rx_valid during RD_PULSE/RD_WAIT/TX_SEND/WR_PULSE: byte dropped, cmd_err pulse, state unaffected.
- addr/wr_data hold their last values in IDLE.
- rst asserted mid-frame: immediate return to reset values. No wr_en/rd_en is generated and any pending tx byte is lost.

Decomposition:
- Shared package sys_pkg:
  - CMD_WR=8'hAA, CMD_RD=8'hBB.
  - State enum ctrl_state_t.
- One sub-module is natural: frame_timer (loadable down-counter with clear, enable and expire outputs), parameterised by TIMEOUT.
- FSM and datapath stay in reg_file_cmd_ctrl.

Test Plan:
- Write: after reset, drive bytes AA,03,34,12 with gaps -> wr_en one cycle, addr=3, wr_data=16'h1234. A following read frame BB,03 returns tx bytes 34 then 12.
- Back-pressure: read addr 5 holding 16'hBEEF; tx_ready low 4 cycles -> tx_data=EF is held stable with tx_valid=1. Raise tx_ready -> EF then EF... no: bytes EF then BE are sent, then tx_valid=0 and busy=0.
- Errors:
  - Byte 55 in IDLE -> cmd_err one pulse, no strobes.
  - AA,09 (bit3 set with LINES=8) -> cmd_err, IDLE, no wr_en.
- Timeout: AA,02,77 then idle TIMEOUT cycles -> cmd_err, IDLE, no wr_en. A read of addr 2 then returns the old value.
- Overrun: byte arriving during TX_SEND -> cmd_err pulse, tx sequence completes unchanged.
- Reset mid-write: rst after AA,01,99 -> all outputs 0, no wr_en. After release, a full write frame is decoded normally.
